if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC, issues word requests to instruction memory over a request/grant/rvalid handshake, and registers the returned instruction into an `id_pipe_t` that feeds decode. Up to one request is outstanding at a time. A one-entry skid buffer absorbs a response that arrives while decode is stalled. Branch/jump redirects and hazard-unit stall/flush are applied cycle-exactly.

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/if_stage.sv | 142 ++++++++++++++
 tb/tb_if_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
//   id_pipe_t  : {instr, pc_plus4} payload handed from IF to ID
//   if_state_t : fetch FSM states
//   NOP_INSTR  : all-zero word (sll $0,$0,0), used for ID bubbles
package if_stage_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } id_pipe_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam id_pipe_t    ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0};

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that arrived while
// decode was stalled.
//   clk, rst_n : clock, synchronous active-low reset (empties the buffer)
//   load       : capture din
//   drop       : empty the buffer (either delivered or discarded)
//   din        : {instr, pc_plus4} to capture
//   full       : buffer holds an entry
//   dout       : buffered entry
module fetch_skid_buf
  import if_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     drop,
  input  id_pipe_t din,
  output logic     full,
  output id_pipe_t dout
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= ID_BUBBLE;
    end else if (drop) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding word requests
// over a req/gnt/rvalid handshake and registers the result into the ID pipe.
//   RESET_PC        : PC loaded on reset
//   clk, rst_n      : clock, synchronous active-low reset
//   redirect_i      : taken branch/jump; redirect_pc_i is the new PC
//   stall_i         : hold the ID register
//   flush_i         : bubble the ID register
//   imem_req_o      : fetch request (combinational), imem_addr_o = pc
//   imem_gnt_i      : request accepted this cycle
//   imem_rvalid_i   : response valid, imem_rdata_i is the instruction word
//   id_pipe_o       : registered {instr, pc_plus4} to decode
//   id_valid_o      : id_pipe_o holds a real instruction
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output id_pipe_t    id_pipe_o,
  output logic        id_valid_o
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pc_req;
  logic        kill;

  logic        grant;
  logic        rsp_live;     // response in S_WAIT that is neither killed nor redirected
  logic        deliver;
  id_pipe_t    deliver_data;
  logic        skid_load;
  logic        skid_drop;
  logic        skid_full;
  id_pipe_t    skid_q;
  id_pipe_t    rsp_data;

  always_comb begin
    imem_req_o = 1'b0;
    if (rst_n && !redirect_i) begin
      unique case (state)
        S_REQ:   imem_req_o = 1'b1;
        S_WAIT:  imem_req_o = imem_rvalid_i && !kill && !stall_i;
        default: imem_req_o = 1'b0;
      endcase
    end
  end

  assign imem_addr_o = pc;
  assign grant       = imem_req_o && imem_gnt_i;

  assign rsp_live  = (state == S_WAIT) && imem_rvalid_i && !kill && !redirect_i;
  assign rsp_data  = '{instr: imem_rdata_i, pc_plus4: pc_req + 32'd4};
  assign skid_load = rsp_live && stall_i;
  assign skid_drop = skid_full && (redirect_i || !stall_i);

  always_comb begin
    deliver      = 1'b0;
    deliver_data = rsp_data;
    if (skid_full) begin
      deliver      = !redirect_i && !stall_i;
      deliver_data = skid_q;
    end else if (rsp_live) begin
      deliver      = !stall_i;
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .drop  (skid_drop),
    .din   (rsp_data),
    .full  (skid_full),
    .dout  (skid_q)
  );

  // PC update is hoisted out of the per-state branches: every state loads the
  // redirect target, and a grant (which implies no redirect) always advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      pc_req <= RESET_PC;
      kill   <= 1'b0;
    end else begin
      if (redirect_i) begin
        pc <= redirect_pc_i;
      end else if (grant) begin
        pc_req <= pc;
        pc     <= pc + 32'd4;
      end
      unique case (state)
        S_REQ: begin
          if (grant) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!imem_rvalid_i) begin
            if (redirect_i) kill <= 1'b1;
          end else if (kill) begin
            kill  <= 1'b0;
            state <= S_REQ;
          end else if (redirect_i) begin
            state <= S_REQ;
          end else if (!stall_i) begin
            state <= grant ? S_WAIT : S_REQ;
          end else begin
            state <= S_FULL;
          end
        end
        S_FULL: begin
          if (redirect_i || !stall_i) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_pipe_o  <= ID_BUBBLE;
      id_valid_o <= 1'b0;
    end else if (flush_i) begin
      id_pipe_o  <= ID_BUBBLE;
      id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      id_pipe_o  <= deliver ? deliver_data : ID_BUBBLE;
      id_valid_o <= deliver;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect, stall, flush, gnt_en, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        req, id_valid;
  logic [31:0] addr;
  id_pipe_t    id_pipe;

  logic        req2, id_valid2, rvalid2;
  logic [31:0] addr2;
  id_pipe_t    id_pipe2;
  logic        s2 = 1'b0;

  if_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .stall_i(stall), .flush_i(flush), .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt_en), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .id_pipe_o(id_pipe), .id_valid_o(id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .stall_i(1'b0), .flush_i(1'b0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_gnt_i(1'b1), .imem_rvalid_i(rvalid2), .imem_rdata_i(32'h1234_5678),
    .id_pipe_o(id_pipe2), .id_valid_o(id_valid2)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Instruction memory contents; unmapped words read as a function of address.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder: fixed latency per grant, emptied by reset.
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rsp_q[$];
  int   cyc = 0;
  int   lat = 1;

  // Reference model at transaction level: the outstanding request (with a
  // stale mark once redirected away from), the held entry, PC and ID register.
  typedef struct { logic [31:0] addr; bit stale; } out_t;
  out_t       out_q[$];
  id_pipe_t   held_q[$];
  logic [31:0] m_pc;
  id_pipe_t   m_id;
  logic       m_valid;
  bit         m_init = 0;

  function automatic logic f_req(input logic rst, input logic redir, input logic rv, input logic st);
    if (!rst || redir || held_q.size() != 0) return 1'b0;
    if (out_q.size() == 0) return 1'b1;
    return rv && !out_q[0].stale && !st;
  endfunction

  // Pre-edge snapshot, taken at the falling edge
  logic        s_rst = 1'b0, s_redir = 1'b0, s_stall = 1'b0, s_flush = 1'b0;
  logic        s_rvalid = 1'b0, s_gnt = 1'b0, s_req = 1'b0, s_exp = 1'b0;
  logic [31:0] s_rpc = '0, s_rdata = '0, s_addr = '0;
  bit          seen_dead = 0, seen_bad = 0;

  // Compare process
  always @(negedge clk) begin
    s_rst = rst_n; s_redir = redirect; s_rpc = redirect_pc; s_stall = stall;
    s_flush = flush; s_rvalid = rvalid; s_rdata = rdata; s_gnt = gnt_en;
    s_req = req; s_addr = addr;
    s_exp = f_req(rst_n, redirect, rvalid, stall);
    if (m_init) begin
      chk("req", {31'b0, req}, {31'b0, s_exp});
      if (s_exp) chk("addr", addr, m_pc);
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      chk("id_instr", id_pipe.instr, m_id.instr);
      chk("id_pc_plus4", id_pipe.pc_plus4, m_id.pc_plus4);
    end
    if (id_valid && id_pipe.instr == 32'hDEAD_BEEF) seen_dead = 1;
    if (id_valid && id_pipe.instr == 32'hBAD0_0001) seen_bad = 1;
    s2 = rst_n && req2;
  end

  always @(posedge clk) begin
    #1 rvalid2 = s2;
  end

  out_t     mo;
  id_pipe_t mv;
  logic     mg, mdlv;

  // Model and responder advance on the rising edge using the snapshot
  always @(posedge clk) begin
    if (!s_rst) begin
      m_pc = 32'h0040_0000; m_id = '0; m_valid = 1'b0;
      out_q.delete(); held_q.delete(); rsp_q.delete();
      m_init = 1;
    end else begin
      mg = s_exp && s_gnt;
      mdlv = 1'b0;
      mv = '0;
      if (s_rvalid && out_q.size() > 0) begin
        mo = out_q.pop_front();
        if (!mo.stale && !s_redir) begin
          mv = '{instr: s_rdata, pc_plus4: mo.addr + 32'd4};
          if (!s_stall) mdlv = 1'b1;
          else held_q.push_back(mv);
        end
      end else if (out_q.size() > 0) begin
        if (s_redir) out_q[0].stale = 1;
      end else if (held_q.size() > 0) begin
        if (s_redir) held_q.delete();
        else if (!s_stall) begin
          mv = held_q.pop_front();
          mdlv = 1'b1;
        end
      end
      if (mg) out_q.push_back('{addr: m_pc, stale: 1'b0});
      if (s_redir) m_pc = s_rpc;
      else if (mg) m_pc = m_pc + 32'd4;
      if (s_flush) begin
        m_id = '0; m_valid = 1'b0;
      end else if (!s_stall) begin
        m_id = mdlv ? mv : '0;
        m_valid = mdlv;
      end
      if (s_rvalid && rsp_q.size() > 0) void'(rsp_q.pop_front());
      if (s_req && s_gnt) rsp_q.push_back('{addr: s_addr, due: cyc + lat});
    end
    cyc++;
    #1;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      rvalid = 1'b1; rdata = mem_rd(rsp_q[0].addr);
    end else begin
      rvalid = 1'b0; rdata = '0;
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; flush = 1'b0;
    gnt_en = 1'b1; rvalid = 1'b0; rdata = '0; rvalid2 = 1'b0;
    mem[32'h0040_0000] = 32'h2008_0005;
    mem[32'h0040_0004] = 32'h2009_0007;
    mem[32'h0040_0008] = 32'h0109_5020;
    mem[32'h0040_000C] = 32'h8C09_0000;
    mem[32'h0040_0010] = 32'hDEAD_BEEF;
    mem[32'h0040_0100] = 32'h3C01_1234;
    mem[32'h0040_0108] = 32'hBAD0_0001;

    repeat (3) go();
    @(negedge clk);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_pipe_instr", id_pipe.instr, 32'h0);
    chk("rst_pipe_pc4", id_pipe.pc_plus4, 32'h0);
    go(); rst_n = 1'b1;                                   // cycle A
    @(negedge clk);
    chk("first_req", {31'b0, req}, 32'd1);
    chk("first_addr", addr, 32'h0040_0000);
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    go();                                                 // A+1
    @(negedge clk);
    chk("wrap_req", {31'b0, req2}, 32'd1);
    chk("wrap_next_addr", addr2, 32'h0);
    go();                                                 // A+2
    @(negedge clk);
    chk("s1_instr", id_pipe.instr, 32'h2008_0005);
    chk("s1_pc4", id_pipe.pc_plus4, 32'h0040_0004);
    chk("s1_valid", {31'b0, id_valid}, 32'd1);
    chk("wrap_valid", {31'b0, id_valid2}, 32'd1);
    chk("wrap_instr", id_pipe2.instr, 32'h1234_5678);
    chk("wrap_pc4", id_pipe2.pc_plus4, 32'h0);
    go();                                                 // A+3
    @(negedge clk);
    chk("s2_instr", id_pipe.instr, 32'h2009_0007);
    chk("s2_pc4", id_pipe.pc_plus4, 32'h0040_0008);
    go(); stall = 1'b1;                                   // A+4
    @(negedge clk);
    chk("s3_instr", id_pipe.instr, 32'h0109_5020);
    chk("s3_pc4", id_pipe.pc_plus4, 32'h0040_000C);
    chk("stall_req", {31'b0, req}, 32'd0);
    go();                                                 // A+5
    @(negedge clk);
    chk("hold_instr", id_pipe.instr, 32'h0109_5020);
    chk("full_req", {31'b0, req}, 32'd0);
    go(); stall = 1'b0; lat = 3;                          // A+6
    @(negedge clk);
    chk("release_req", {31'b0, req}, 32'd0);
    go();                                                 // A+7
    @(negedge clk);
    chk("skid_instr", id_pipe.instr, 32'h8C09_0000);
    chk("skid_pc4", id_pipe.pc_plus4, 32'h0040_0010);
    chk("resume_req", {31'b0, req}, 32'd1);
    chk("resume_addr", addr, 32'h0040_0010);
    go(); redirect = 1'b1; redirect_pc = 32'h0040_0100;   // A+8
    @(negedge clk);
    chk("redir_req", {31'b0, req}, 32'd0);
    go(); redirect = 1'b0;                                // A+9
    go(); lat = 1;                                        // A+10
    @(negedge clk);
    chk("stale_rvalid", {31'b0, rvalid}, 32'd1);
    chk("kill_req", {31'b0, req}, 32'd0);
    go();                                                 // A+11
    @(negedge clk);
    chk("redir_addr", addr, 32'h0040_0100);
    chk("redir_req1", {31'b0, req}, 32'd1);
    go();                                                 // A+12
    go(); flush = 1'b1; stall = 1'b1;                     // A+13
    @(negedge clk);
    chk("redir_instr", id_pipe.instr, 32'h3C01_1234);
    chk("redir_pc4", id_pipe.pc_plus4, 32'h0040_0104);
    go(); flush = 1'b0; stall = 1'b0; lat = 3;            // A+14
    @(negedge clk);
    chk("flush_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_instr", id_pipe.instr, 32'h0);
    go();                                                 // A+15
    @(negedge clk);
    chk("post_flush_pc4", id_pipe.pc_plus4, 32'h0040_0108);
    go(); rst_n = 1'b0; lat = 1;                          // A+16
    go();                                                 // A+17
    go(); rst_n = 1'b1;                                   // A+18
    @(negedge clk);
    chk("rerst_addr", addr, 32'h0040_0000);
    chk("rerst_req", {31'b0, req}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      go();
      gnt_en      = !(i == 3 || i == 4 || i == 9);
      redirect    = (i == 6 || i == 10);
      redirect_pc = (i == 6) ? 32'h0040_0200 : 32'h0040_0300;
      stall       = (i == 8 || i == 11 || i == 12);
      flush       = (i == 12);
    end
    go(); redirect = 1'b0; stall = 1'b0; flush = 1'b0; gnt_en = 1'b1;
    repeat (6) go();
    @(negedge clk);
    chk("never_dead", {31'b0, seen_dead}, 32'd0);
    chk("never_prereset", {31'b0, seen_bad}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
